// File: rtl/cordic_seq_ctrl_if.sv
// Handshake bundle between the CORDIC sequencer, its two requesters, the
// carry-save sign detector, the iterative datapath and the completion consumer.
// master = the sequencer, slave = everything around it.
interface cordic_seq_ctrl_if;
    logic       req0;
    logic       req1;
    logic       ack0;
    logic       ack1;
    logic       dp_sel;
    logic       dp_load;
    logic       sd_start;
    logic       sd_done;
    logic       sd_sgn;
    logic       dp_en;
    logic       dp_dir;
    logic [3:0] dp_iter;
    logic       busy;
    logic       out_valid;
    logic       out_id;
    logic       out_err;
    logic       out_ready;

    modport master (
        input  req0, req1, sd_done, sd_sgn, out_ready,
        output ack0, ack1, dp_sel, dp_load, sd_start, dp_en, dp_dir, dp_iter,
               busy, out_valid, out_id, out_err
    );

    modport slave (
        output req0, req1, sd_done, sd_sgn, out_ready,
        input  ack0, ack1, dp_sel, dp_load, sd_start, dp_en, dp_dir, dp_iter,
               busy, out_valid, out_id, out_err
    );
endinterface

// File: rtl/cordic_seq_ctrl.sv
// Iteration sequencer and round-robin arbiter for the shared iterative CORDIC
// stage. Each job: LOAD, then N_ITER x (ISSUE -> WAIT -> STEP), then DONE until
// the consumer accepts. Every output is a flop decoded from the next state, so
// no input reaches an output combinationally.
module cordic_seq_ctrl #(
    parameter int N_ITER  = 16,
    parameter int TIMEOUT = 15
) (
    input  logic               clk,
    input  logic               reset,
    cordic_seq_ctrl_if.master  bus
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_ISSUE,
        S_WAIT,
        S_STEP,
        S_DONE
    } state_t;

    localparam logic [3:0] LAST_ITER = 4'(N_ITER - 1);
    localparam logic [7:0] LAST_WAIT = 8'(TIMEOUT - 1);

    state_t     state_q, state_d;
    // Requester that wins the next tie; reset to 0 so req0 wins the first one,
    // and set to the loser on every grant.
    logic       prio_q, prio_d;
    logic       sel_q, sel_d;
    logic [3:0] iter_q, iter_d;
    logic [7:0] tmo_q, tmo_d;
    logic       dir_q, dir_d;
    logic       err_q, err_d;
    logic       gnt;

    logic ack0_q, ack0_d, ack1_q, ack1_d;
    logic dp_load_q, dp_load_d, sd_start_q, sd_start_d, dp_en_q, dp_en_d;
    logic busy_q, busy_d, out_valid_q, out_valid_d;
    logic out_id_q, out_id_d, out_err_q, out_err_d;

    // Next-state, job bookkeeping and the registered outputs of the next state.
    always_comb begin
        // NOTE: every _d gets a default before the case so no path leaves one
        // unassigned; that is what keeps this block free of inferred latches.
        state_d = state_q;
        prio_d  = prio_q;
        sel_d   = sel_q;
        iter_d  = iter_q;
        tmo_d   = tmo_q;
        dir_d   = dir_q;
        err_d   = err_q;
        gnt     = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (bus.req0 || bus.req1) begin
                    gnt     = (bus.req0 && bus.req1) ? prio_q : bus.req1;
                    sel_d   = gnt;
                    prio_d  = ~gnt;
                    iter_d  = '0;
                    err_d   = 1'b0;
                    state_d = S_LOAD;
                end
            end
            S_LOAD: state_d = S_ISSUE;
            S_ISSUE: begin
                tmo_d   = '0;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                // A result in the last allowed WAIT cycle still wins over the abort.
                if (bus.sd_done) begin
                    dir_d   = bus.sd_sgn;
                    state_d = S_STEP;
                end else if (tmo_q == LAST_WAIT) begin
                    err_d   = 1'b1;
                    state_d = S_DONE;
                end else begin
                    tmo_d = tmo_q + 8'd1;
                end
            end
            S_STEP: begin
                if (iter_q == LAST_ITER) begin
                    err_d   = 1'b0;
                    state_d = S_DONE;
                end else begin
                    iter_d  = iter_q + 4'd1;
                    state_d = S_ISSUE;
                end
            end
            S_DONE: begin
                if (bus.out_ready) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        ack0_d      = (state_d == S_LOAD) && !sel_d;
        ack1_d      = (state_d == S_LOAD) && sel_d;
        dp_load_d   = (state_d == S_LOAD);
        sd_start_d  = (state_d == S_ISSUE);
        dp_en_d     = (state_d == S_STEP);
        busy_d      = (state_d != S_IDLE);
        out_valid_d = (state_d == S_DONE);
        out_id_d    = (state_d == S_DONE) && sel_d;
        out_err_d   = (state_d == S_DONE) && err_d;
    end

    // All state and output flops; reset aborts any job without a completion.
    always_ff @(posedge clk or posedge reset) begin
        // NOTE: non-blocking assignments here so every flop samples the values
        // from before this edge, independent of statement order.
        if (reset) begin
            state_q     <= S_IDLE;
            prio_q      <= 1'b0;
            sel_q       <= 1'b0;
            iter_q      <= '0;
            tmo_q       <= '0;
            dir_q       <= 1'b0;
            err_q       <= 1'b0;
            ack0_q      <= 1'b0;
            ack1_q      <= 1'b0;
            dp_load_q   <= 1'b0;
            sd_start_q  <= 1'b0;
            dp_en_q     <= 1'b0;
            busy_q      <= 1'b0;
            out_valid_q <= 1'b0;
            out_id_q    <= 1'b0;
            out_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            prio_q      <= prio_d;
            sel_q       <= sel_d;
            iter_q      <= iter_d;
            tmo_q       <= tmo_d;
            dir_q       <= dir_d;
            err_q       <= err_d;
            ack0_q      <= ack0_d;
            ack1_q      <= ack1_d;
            dp_load_q   <= dp_load_d;
            sd_start_q  <= sd_start_d;
            dp_en_q     <= dp_en_d;
            busy_q      <= busy_d;
            out_valid_q <= out_valid_d;
            out_id_q    <= out_id_d;
            out_err_q   <= out_err_d;
        end
    end

    assign bus.ack0      = ack0_q;
    assign bus.ack1      = ack1_q;
    assign bus.dp_sel    = sel_q;
    assign bus.dp_load   = dp_load_q;
    assign bus.sd_start  = sd_start_q;
    assign bus.dp_en     = dp_en_q;
    assign bus.dp_dir    = dir_q;
    assign bus.dp_iter   = iter_q;
    assign bus.busy      = busy_q;
    assign bus.out_valid = out_valid_q;
    assign bus.out_id    = out_id_q;
    assign bus.out_err   = out_err_q;

endmodule

// File: tb/tb_cordic_seq_ctrl.sv
// Self-checking bench for cordic_seq_ctrl: a sign-detector responder driven
// from per-iteration tables, with expected timing/steps computed from the
// job rules (LOAD, ISSUE+WAIT+STEP per iteration, timeout abort, DONE hold).
module tb_cordic_seq_ctrl;

    localparam int N_ITER  = 16;
    localparam int TIMEOUT = 15;

    logic clk = 1'b0;
    logic reset;
    cordic_seq_ctrl_if bus ();

    cordic_seq_ctrl #(.N_ITER(N_ITER), .TIMEOUT(TIMEOUT)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int model_last = 1;            // id granted last; 1 after reset so req0 wins a tie

    int delay_tab [N_ITER];        // WAIT cycle (1-based) carrying sd_done; 0 = never
    bit sgn_tab   [N_ITER];

    int          ack_cnt [2];
    int          ack_cyc [2];
    int          step_iter [$];
    bit          step_dir  [$];
    int          valid_cyc, last_start_cyc, done_cycles;
    logic        got_id, got_err;
    bit          unstable, finished, aborted;
    logic [14:0] outs_at_abort;

    function automatic logic [14:0] outs();
        return {bus.ack0, bus.ack1, bus.dp_sel, bus.dp_load, bus.sd_start, bus.dp_en,
                bus.dp_dir, bus.dp_iter, bus.busy, bus.out_valid, bus.out_id, bus.out_err};
    endfunction

    // Iterations that complete before the first withheld / too-late result.
    function automatic int model_steps();
        for (int k = 0; k < N_ITER; k++)
            if (delay_tab[k] == 0 || delay_tab[k] > TIMEOUT) return k;
        return N_ITER;
    endfunction

    // Cycle (LOAD = 1) in which out_valid first rises.
    function automatic int model_done_cycle();
        int c = 1;
        int n = model_steps();
        for (int k = 0; k < n; k++) c += 2 + delay_tab[k];
        if (n < N_ITER) c += 1 + TIMEOUT;
        return c + 1;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        bus.req0 = 0; bus.req1 = 0; bus.sd_done = 0; bus.sd_sgn = 0; bus.out_ready = 0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        model_last = 1;
    endtask

    // Runs one job from the current IDLE cycle (cycle 0) to the first IDLE
    // cycle after DONE, acting as sign detector and consumer, recording what it sees.
    task automatic run_job(input int ready_delay, input bit drop_req,
                           input bit req1_in_done, input int abort_iter);
        int  cnt, cur, starts;
        bit  in_done;
        ack_cnt = '{0, 0}; ack_cyc = '{-1, -1};
        step_iter.delete(); step_dir.delete();
        valid_cyc = -1; last_start_cyc = -1; done_cycles = 0;
        unstable = 0; finished = 0; aborted = 0;
        cnt = -1; cur = 0; starts = 0; in_done = 0;
        for (int cyc = 1; cyc <= 1000 && !finished && !aborted; cyc++) begin
            tick();
            if (bus.ack0 === 1'b1) begin ack_cnt[0]++; ack_cyc[0] = cyc; end
            if (bus.ack1 === 1'b1) begin ack_cnt[1]++; ack_cyc[1] = cyc; end
            if (bus.dp_en === 1'b1) begin
                step_iter.push_back(int'(bus.dp_iter));
                step_dir.push_back(bus.dp_dir);
            end
            if (bus.sd_start === 1'b1) begin
                cur = starts; starts++; cnt = 0; last_start_cyc = cyc;
            end else if (cnt >= 0) begin
                cnt++;
            end
            if (drop_req && (bus.ack0 === 1'b1 || bus.ack1 === 1'b1)) begin
                bus.req0 = 0; bus.req1 = 0;
            end
            if (bus.out_valid === 1'b1) begin
                if (!in_done) begin
                    in_done = 1; valid_cyc = cyc; got_id = bus.out_id; got_err = bus.out_err;
                    if (req1_in_done) bus.req1 = 1;
                end else if (bus.out_id !== got_id || bus.out_err !== got_err) begin
                    unstable = 1;
                end
                if (bus.busy !== 1'b1) unstable = 1;
                done_cycles++;
                bus.out_ready = (done_cycles > ready_delay);
            end else begin
                if (in_done) finished = 1;
                bus.out_ready = 1'($urandom);
            end
            bus.sd_done = (cur < N_ITER) && (cnt > 0) && (cnt == delay_tab[cur]);
            bus.sd_sgn  = bus.sd_done ? sgn_tab[cur] : 1'($urandom);
            if (abort_iter >= 0 && cur == abort_iter && cnt == 1) begin
                #2 reset = 1'b1;
                #1 outs_at_abort = outs();
                aborted = 1;
            end
        end
        bus.sd_done = 0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        bus.req0 = 1; bus.req1 = 1; bus.sd_done = 0; bus.sd_sgn = 0; bus.out_ready = 0;
        #12;
        total++;
        if (outs() !== '0) begin
            bad++; $display("FAIL reset_outputs_held: got %h want 0", outs());
        end
        do_reset();
        total++;
        if (outs() !== '0) begin
            bad++; $display("FAIL reset_outputs_after: got %h want 0", outs());
        end
        tick();
        total++;
        if (bus.busy !== 1'b0) begin
            bad++; $display("FAIL reset_idle_busy: got %b want 0", bus.busy);
        end
    endtask

    task automatic test_single_job();
        for (int k = 0; k < N_ITER; k++) begin delay_tab[k] = 1; sgn_tab[k] = (k % 2 == 0); end
        bus.req0 = 1;
        run_job(0, 1, 0, -1);
        model_last = 0;
        total++;
        if (!finished) begin bad++; $display("FAIL single_finish: got 0 want 1"); end
        total++;
        if (ack_cyc[0] !== 1 || ack_cnt[0] !== 1 || ack_cnt[1] !== 0) begin
            bad++; $display("FAIL single_ack: got cyc=%0d n0=%0d n1=%0d want 1 1 0",
                            ack_cyc[0], ack_cnt[0], ack_cnt[1]);
        end
        total++;
        if (step_iter.size() !== N_ITER) begin
            bad++; $display("FAIL single_steps: got %0d want %0d", step_iter.size(), N_ITER);
        end
        for (int k = 0; k < step_iter.size() && k < N_ITER; k++) begin
            total++;
            if (step_iter[k] !== k || step_dir[k] !== (k % 2 == 0)) begin
                bad++; $display("FAIL single_step%0d: got iter=%0d dir=%b want %0d %b",
                                k, step_iter[k], step_dir[k], k, (k % 2 == 0));
            end
        end
        total++;
        if (valid_cyc !== 3 * N_ITER + 2 || got_id !== 1'b0 || got_err !== 1'b0) begin
            bad++; $display("FAIL single_done: got cyc=%0d id=%b err=%b want %0d 0 0",
                            valid_cyc, got_id, got_err, 3 * N_ITER + 2);
        end
    endtask

    task automatic test_random_jobs();
        for (int j = 0; j < 6; j++) begin
            int r, exp_id, exp_n;
            r = $urandom_range(1, 3);
            for (int k = 0; k < N_ITER; k++) begin
                delay_tab[k] = $urandom_range(1, TIMEOUT);
                sgn_tab[k]   = 1'($urandom);
            end
            if (j % 3 == 2) delay_tab[$urandom_range(0, N_ITER - 1)] = 0;
            exp_id = (r == 3) ? 1 - model_last : (r == 2 ? 1 : 0);
            model_last = exp_id;
            exp_n = model_steps();
            bus.req0 = r[0]; bus.req1 = r[1];
            run_job($urandom_range(0, 3), 1, 0, -1);
            total++;
            if (!finished || ack_cyc[exp_id] !== 1 || ack_cnt[exp_id] !== 1 || ack_cnt[1 - exp_id] !== 0) begin
                bad++; $display("FAIL rand%0d_grant: got fin=%b cyc=%0d n0=%0d n1=%0d want id %0d",
                                j, finished, ack_cyc[exp_id], ack_cnt[0], ack_cnt[1], exp_id);
            end
            total++;
            if (step_iter.size() !== exp_n) begin
                bad++; $display("FAIL rand%0d_steps: got %0d want %0d", j, step_iter.size(), exp_n);
            end
            for (int k = 0; k < step_iter.size() && k < exp_n; k++) begin
                total++;
                if (step_iter[k] !== k || step_dir[k] !== sgn_tab[k]) begin
                    bad++; $display("FAIL rand%0d_step%0d: got iter=%0d dir=%b want %0d %b",
                                    j, k, step_iter[k], step_dir[k], k, sgn_tab[k]);
                end
            end
            total++;
            if (valid_cyc !== model_done_cycle() || got_id !== exp_id[0] || got_err !== (exp_n < N_ITER)) begin
                bad++; $display("FAIL rand%0d_done: got cyc=%0d id=%b err=%b want %0d %0d %b",
                                j, valid_cyc, got_id, got_err, model_done_cycle(), exp_id, exp_n < N_ITER);
            end
        end
    endtask

    task automatic test_round_robin();
        do_reset();
        for (int k = 0; k < N_ITER; k++) begin delay_tab[k] = 1; sgn_tab[k] = 1'($urandom); end
        bus.req0 = 1; bus.req1 = 1;
        for (int j = 0; j < 4; j++) begin
            int exp_id;
            exp_id = 1 - model_last;
            model_last = exp_id;
            run_job(0, 0, 0, -1);
            if (j == 3) begin bus.req0 = 0; bus.req1 = 0; end
            total++;
            if (!finished || ack_cyc[exp_id] !== 1 || ack_cnt[exp_id] !== 1 ||
                ack_cnt[1 - exp_id] !== 0 || got_id !== exp_id[0]) begin
                bad++; $display("FAIL rr%0d_grant: got n0=%0d n1=%0d id=%b want id %0d",
                                j, ack_cnt[0], ack_cnt[1], got_id, exp_id);
            end
        end
    endtask

    task automatic test_timeout();
        for (int k = 0; k < N_ITER; k++) begin delay_tab[k] = 1; sgn_tab[k] = 1'($urandom); end
        delay_tab[3] = 0;
        bus.req1 = 1;
        run_job(0, 1, 0, -1);
        model_last = 1;
        total++;
        if (step_iter.size() !== 3 || (step_iter.size() == 3 && step_iter[2] !== 2)) begin
            bad++; $display("FAIL timeout_steps: got %0d want 3", step_iter.size());
        end
        total++;
        if (valid_cyc - last_start_cyc - 1 !== TIMEOUT) begin
            bad++; $display("FAIL timeout_wait_cycles: got %0d want %0d",
                            valid_cyc - last_start_cyc - 1, TIMEOUT);
        end
        total++;
        if (!finished || valid_cyc !== 27 || got_err !== 1'b1 || got_id !== 1'b1) begin
            bad++; $display("FAIL timeout_done: got cyc=%0d err=%b id=%b want 27 1 1",
                            valid_cyc, got_err, got_id);
        end
    endtask

    task automatic test_late_done();
        for (int k = 0; k < N_ITER; k++) begin delay_tab[k] = 1; sgn_tab[k] = 1'($urandom); end
        delay_tab[5] = TIMEOUT;
        bus.req0 = 1;
        run_job(0, 1, 0, -1);
        model_last = 0;
        total++;
        if (step_iter.size() !== N_ITER || (step_iter.size() > 5 && step_dir[5] !== sgn_tab[5])) begin
            bad++; $display("FAIL late_steps: got %0d want %0d", step_iter.size(), N_ITER);
        end
        total++;
        if (!finished || valid_cyc !== 3 * N_ITER + 2 + TIMEOUT - 1 || got_err !== 1'b0) begin
            bad++; $display("FAIL late_done: got cyc=%0d err=%b want %0d 0",
                            valid_cyc, got_err, 3 * N_ITER + 1 + TIMEOUT);
        end
    endtask

    task automatic test_backpressure();
        for (int k = 0; k < N_ITER; k++) begin delay_tab[k] = 1; sgn_tab[k] = 1'($urandom); end
        bus.req0 = 1;
        run_job(10, 1, 1, -1);
        model_last = 0;
        total++;
        if (!finished || done_cycles !== 11 || unstable !== 1'b0) begin
            bad++; $display("FAIL bp_hold: got fin=%b done_cycles=%0d unstable=%b want 1 11 0",
                            finished, done_cycles, unstable);
        end
        total++;
        if (ack_cnt[1] !== 0) begin
            bad++; $display("FAIL bp_early_ack1: got %0d want 0", ack_cnt[1]);
        end
        run_job(0, 1, 0, -1);
        model_last = 1;
        total++;
        if (!finished || ack_cyc[1] !== 1 || ack_cnt[1] !== 1 || got_id !== 1'b1) begin
            bad++; $display("FAIL bp_next_grant: got cyc=%0d n1=%0d id=%b want 1 1 1",
                            ack_cyc[1], ack_cnt[1], got_id);
        end
    endtask

    task automatic test_async_reset();
        int seen;
        for (int k = 0; k < N_ITER; k++) begin delay_tab[k] = 1; sgn_tab[k] = 1'($urandom); end
        delay_tab[7] = 0;
        bus.req0 = 1;
        run_job(0, 1, 0, 7);
        total++;
        if (!aborted || outs_at_abort !== '0) begin
            bad++; $display("FAIL areset_immediate: got aborted=%b outs=%h want 1 0",
                            aborted, outs_at_abort);
        end
        seen = 0;
        repeat (3) begin
            tick();
            if (bus.out_valid !== 1'b0 || bus.dp_en !== 1'b0) seen++;
        end
        #2 reset = 1'b0;
        model_last = 1;
        for (int k = 0; k < 5; k++) begin
            tick();
            if (bus.out_valid !== 1'b0 || bus.dp_en !== 1'b0 || bus.busy !== 1'b0) seen++;
        end
        total++;
        if (seen !== 0) begin
            bad++; $display("FAIL areset_quiet: got %0d active cycles want 0", seen);
        end
        for (int k = 0; k < N_ITER; k++) delay_tab[k] = 1;
        bus.req0 = 1; bus.req1 = 1;
        run_job(0, 1, 0, -1);
        total++;
        if (!finished || ack_cyc[0] !== 1 || ack_cnt[0] !== 1 || ack_cnt[1] !== 0 || got_id !== 1'b0) begin
            bad++; $display("FAIL areset_tie: got n0=%0d n1=%0d id=%b want 1 0 0",
                            ack_cnt[0], ack_cnt[1], got_id);
        end
    endtask

    initial begin
        test_reset();
        test_single_job();
        test_random_jobs();
        test_round_robin();
        test_timeout();
        test_late_done();
        test_backpressure();
        test_async_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
